// File: rtl/ghost_motion_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ghost_motion_scheduler
// Purpose  : Time-multiplexed motion controller for up to NUM_GHOSTS bouncing
//            sprites. A free-running divider produces a motion tick. On each
//            tick the block sweeps the ghosts one per clock through a single
//            shared add/compare datapath. For each ghost it applies either a
//            latched collision reversal or a wall bounce, and otherwise takes
//            one step.
// Ports    : clk         - system clock
//            resetN      - asynchronous active-low reset
//            enable      - per-ghost active mask
//            collision   - per-ghost collision pulse (latched until serviced)
//            topLeft_x   - ghost i x at [11i+10:11i]
//            topLeft_y   - ghost i y at [11i+10:11i]
//            x_direction - per-ghost facing flag, toggles on each x reversal
//            busy        - high while a sweep is in progress
//            frame_tick  - one-cycle pulse when a sweep completes
// Revision : 1.0 - initial release
// ============================================================================
module ghost_motion_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int DIVIDER    = 125000,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int OBJ_SIZE   = 64,
  parameter int BORDER     = 5,
  parameter int X_SPACING  = 128,
  parameter int Y_INIT     = 240
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_GHOSTS-1:0]   enable,
  input  logic [NUM_GHOSTS-1:0]   collision,
  output logic [11*NUM_GHOSTS-1:0] topLeft_x,
  output logic [11*NUM_GHOSTS-1:0] topLeft_y,
  output logic [NUM_GHOSTS-1:0]   x_direction,
  output logic                    busy,
  output logic                    frame_tick
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

  // Bounce limits, in the same 12-bit signed domain as the step result
  localparam logic signed [11:0] LIM_LO = 12'(BORDER);
  localparam logic signed [11:0] LIM_XH = 12'(SCREEN_W - BORDER - OBJ_SIZE);
  localparam logic signed [11:0] LIM_YH = 12'(SCREEN_H - BORDER - OBJ_SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [CNT_W-1:0]      div_cnt;
  logic                  tick;
  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;

  logic [10:0]           pos_x [NUM_GHOSTS];
  logic [10:0]           pos_y [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] sx_neg;   // 1 = x speed is -1
  logic [NUM_GHOSTS-1:0] sy_neg;   // 1 = y speed is -1
  logic [NUM_GHOSTS-1:0] pending;  // latched collision awaiting service

  // Shared datapath: operands of the ghost currently being serviced
  logic                  in_scan;
  logic [10:0]           cur_x;
  logic [10:0]           cur_y;
  logic                  cur_sx_neg;
  logic                  cur_sy_neg;
  logic                  cur_en;
  logic                  cur_pend;
  logic signed [11:0]    nx;
  logic signed [11:0]    ny;
  logic                  hit_x;
  logic                  hit_y;
  logic [NUM_GHOSTS-1:0] serviced;

  assign tick       = (div_cnt == CNT_W'(DIVIDER - 1));
  assign in_scan    = (state == ST_SCAN);
  assign cur_x      = pos_x[idx];
  assign cur_y      = pos_y[idx];
  assign cur_sx_neg = sx_neg[idx];
  assign cur_sy_neg = sy_neg[idx];
  assign cur_en     = enable[idx];
  assign cur_pend   = pending[idx];

  assign nx = $signed({1'b0, cur_x}) + (cur_sx_neg ? -12'sd1 : 12'sd1);
  assign ny = $signed({1'b0, cur_y}) + (cur_sy_neg ? -12'sd1 : 12'sd1);

  assign hit_x = (nx <= LIM_LO) || (nx >= LIM_XH);
  assign hit_y = (ny <= LIM_LO) || (ny >= LIM_YH);

  assign serviced = in_scan ? (NUM_GHOSTS'(1) << idx) : '0;

  // Divider and sweep sequencer
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt    <= '0;
      state      <= ST_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      frame_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_SCAN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (idx == IDX_W'(NUM_GHOSTS - 1)) begin
            state      <= ST_DONE;
            frame_tick <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Collision latch: a new collision in the service cycle outlives the clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending <= '0;
    end else begin
      pending <= (collision & enable) | (pending & ~serviced);
    end
  end

  // Per-ghost motion state, written only for the ghost under service
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        pos_x[i]  <= 11'(BORDER + 1 + i * X_SPACING);
        pos_y[i]  <= 11'(Y_INIT);
        sx_neg[i] <= 1'b0;
        sy_neg[i] <= 1'((i % 2) != 0);
      end
      x_direction <= '0;
    end else if (in_scan && cur_en) begin
      if (cur_pend) begin
        // Collision reversal takes the whole sweep; position holds
        sx_neg[idx]      <= ~cur_sx_neg;
        sy_neg[idx]      <= ~cur_sy_neg;
        x_direction[idx] <= ~x_direction[idx];
      end else begin
        if (hit_x) begin
          sx_neg[idx]      <= ~cur_sx_neg;
          x_direction[idx] <= ~x_direction[idx];
        end else begin
          pos_x[idx] <= nx[10:0];
        end
        if (hit_y) begin
          sy_neg[idx] <= ~cur_sy_neg;
        end else begin
          pos_y[idx] <= ny[10:0];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
      assign topLeft_x[11*g +: 11] = pos_x[g];
      assign topLeft_y[11*g +: 11] = pos_y[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_motion_scheduler
// Purpose  : Directed self-checking bench for ghost_motion_scheduler with
//            DIVIDER=8 and NUM_GHOSTS=4. Expected positions are hand-derived
//            from the motion rules for each sweep number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_motion_scheduler;

  localparam int NG = 4;

  logic            clk;
  logic            resetN;
  logic [NG-1:0]   enable;
  logic [NG-1:0]   collision;
  logic [11*NG-1:0] topLeft_x;
  logic [11*NG-1:0] topLeft_y;
  logic [NG-1:0]   x_direction;
  logic            busy;
  logic            frame_tick;

  int checks = 0;
  int errors = 0;
  int sweeps = 0;

  ghost_motion_scheduler #(
    .NUM_GHOSTS(NG),
    .DIVIDER   (8),
    .SCREEN_W  (640),
    .SCREEN_H  (480),
    .OBJ_SIZE  (64),
    .BORDER    (5),
    .X_SPACING (128),
    .Y_INIT    (240)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .enable     (enable),
    .collision  (collision),
    .topLeft_x  (topLeft_x),
    .topLeft_y  (topLeft_y),
    .x_direction(x_direction),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] gx(input int i);
    return {21'b0, topLeft_x[11*i +: 11]};
  endfunction

  function automatic logic [31:0] gy(input int i);
    return {21'b0, topLeft_y[11*i +: 11]};
  endfunction

  task automatic check_ghost(input string tag, input int i, input int ex, input int ey);
    check_eq($sformatf("%s_g%0d_x", tag, i), gx(i), ex);
    check_eq($sformatf("%s_g%0d_y", tag, i), gy(i), ey);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance to the next DONE cycle (frame_tick high), bounded
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 20);
    check_eq("frame_seen", {31'b0, frame_tick}, 1);
    sweeps++;
  endtask

  task automatic run_to_sweep(input int target);
    while (sweeps < target) wait_frame();
  endtask

  task automatic check_reset_state(input string tag);
    check_ghost(tag, 0, 6, 240);
    check_ghost(tag, 1, 134, 240);
    check_ghost(tag, 2, 262, 240);
    check_ghost(tag, 3, 390, 240);
    check_eq({tag, "_dir"}, {28'b0, x_direction}, 0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 0);
    check_eq({tag, "_ftick"}, {31'b0, frame_tick}, 0);
  endtask

  initial begin
    int n;
    resetN    = 1'b0;
    enable    = 4'hF;
    collision = 4'h0;
    step();
    step();
    check_reset_state("rst");

    // Release and hold: counter starts at 0, first tick at 8th edge
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_reset_state($sformatf("hold%0d", k));
    end
    repeat (5) step();            // after edge 8: tick taken, SCAN idx0
    check_eq("sweep1_busy", {31'b0, busy}, 1);
    check_ghost("pre_g0", 0, 6, 240);
    step();                       // ghost0 serviced
    check_ghost("s1c0", 0, 7, 241);
    check_ghost("s1c0", 1, 134, 240);
    step();                       // ghost1 serviced
    check_ghost("s1c1", 1, 135, 239);
    check_ghost("s1c1", 2, 262, 240);
    step();                       // ghost2 serviced
    check_ghost("s1c2", 2, 263, 241);
    check_eq("s1c2_ftick", {31'b0, frame_tick}, 0);
    step();                       // ghost3 serviced, DONE
    check_ghost("s1c3", 3, 391, 239);
    check_eq("s1_ftick", {31'b0, frame_tick}, 1);
    check_eq("s1_busy", {31'b0, busy}, 1);
    sweeps = 1;

    // Collision on ghost2 mid-interval, and tick period measurement
    step();
    check_eq("post_ftick", {31'b0, frame_tick}, 0);
    check_eq("post_busy", {31'b0, busy}, 0);
    collision[2] = 1'b1;
    step();
    collision[2] = 1'b0;
    n = 2;
    while (frame_tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq("tick_period", n, 8);
    sweeps = 2;
    check_ghost("coll_s2", 2, 263, 241);
    check_eq("coll_s2_dir", {28'b0, x_direction}, 4'b0100);
    check_ghost("coll_s2", 0, 8, 242);
    wait_frame();                 // sweep 3: reversed speeds
    check_ghost("coll_s3", 2, 262, 240);
    check_eq("coll_s3_dir", {28'b0, x_direction}, 4'b0100);

    // Collision landing in ghost2's own service cycle
    repeat (6) step();
    check_eq("svc_busy", {31'b0, busy}, 1);
    check_ghost("svc_pre", 2, 262, 240);
    check_ghost("svc_pre", 1, 138, 236);
    collision[2] = 1'b1;
    step();
    collision[2] = 1'b0;
    check_ghost("svc_s4", 2, 261, 239);
    wait_frame();                 // sweep 4 complete
    check_eq("svc_s4_dir", {28'b0, x_direction}, 4'b0100);
    wait_frame();                 // sweep 5: deferred reversal
    check_ghost("svc_s5", 2, 261, 239);
    check_eq("svc_s5_dir", {28'b0, x_direction}, 4'b0000);
    wait_frame();                 // sweep 6
    check_ghost("svc_s6", 2, 262, 240);

    // Ghost1 disabled for sweeps 7..11, collision on it ignored
    step();
    enable       = 4'b1101;
    collision[1] = 1'b1;
    step();
    collision[1] = 1'b0;
    wait_frame();
    check_ghost("dis_s7", 1, 140, 234);
    check_ghost("dis_s7", 0, 13, 247);
    run_to_sweep(11);
    check_ghost("dis_s11", 1, 140, 234);
    step();
    enable = 4'hF;
    wait_frame();                 // sweep 12: normal step, no reversal
    check_ghost("en_s12", 1, 141, 233);
    check_ghost("en_s12", 0, 18, 252);
    check_eq("en_s12_dir", {28'b0, x_direction}, 4'b0000);

    // Ghost3 right wall
    run_to_sweep(180);
    check_ghost("wall_s180", 3, 570, 60);
    check_eq("wall_s180_dir3", {31'b0, x_direction[3]}, 0);
    wait_frame();
    check_eq("wall_s181_x3", gx(3), 570);
    check_eq("wall_s181_dir3", {31'b0, x_direction[3]}, 1);
    wait_frame();
    check_eq("wall_s182_x3", gx(3), 569);
    check_eq("wall_s182_y3", gy(3), 58);

    // Ghost1 top wall
    run_to_sweep(239);
    check_eq("top_s239_y1", gy(1), 6);
    wait_frame();
    check_eq("top_s240_y1", gy(1), 6);
    check_eq("top_s240_dir1", {31'b0, x_direction[1]}, 0);
    wait_frame();
    check_eq("top_s241_y1", gy(1), 7);
    check_eq("top_s241_x1", gx(1), 370);

    // Asynchronous reset during SCAN
    repeat (5) step();
    check_eq("abort_busy_pre", {31'b0, busy}, 1);
    #1 resetN = 1'b0;
    #1 check_reset_state("abort");
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_reset_state($sformatf("abort_hold%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_motion_scheduler.md
# ghost_motion_scheduler

Time-multiplexed motion controller for up to `NUM_GHOSTS` bouncing sprites. One shared add/compare datapath serves all ghosts. The block holds every ghost's position, per-axis speed sign and facing flag. On each divider tick it sweeps the ghosts one per clock, applying collision reversal or wall bounce before the step. It sits between the collision matrix and the sprite drawers, and replaces per-ghost free-running movers.

## Interface
Parameters:
- `NUM_GHOSTS`, 4 — number of ghosts (1..8)
- `DIVIDER`, 125000 — clocks per motion tick; must be ≥ `NUM_GHOSTS`+2
- `SCREEN_W`, 640 — screen width in pixels
- `SCREEN_H`, 480 — screen height in pixels
- `OBJ_SIZE`, 64 — sprite edge length in pixels
- `BORDER`, 5 — wall margin in pixels
- `X_SPACING`, 128 — initial horizontal spacing between ghosts
- `Y_INIT`, 240 — initial y of every ghost

Ports:
- `clk`  in  1  — system clock
- `resetN`  in  1  — reset; asynchronous, active-low
- `enable`  in  NUM_GHOSTS  — per-ghost active mask
- `collision`  in  NUM_GHOSTS  — per-ghost collision pulse, any width
- `topLeft_x`  out  11*NUM_GHOSTS  — ghost i x at bits [11i+10:11i], unsigned
- `topLeft_y`  out  11*NUM_GHOSTS  — ghost i y, same packing
- `x_direction`  out  NUM_GHOSTS  — facing flag; toggles on every x reversal
- `busy`  out  1  — high while a sweep is in progress
- `frame_tick`  out  1  — one-cycle pulse when a sweep completes

## Operation
Reset (async, `resetN`=0) sets:
- ghost i: x = BORDER+1+i*X_SPACING, y = Y_INIT
- x speed +1 for all ghosts; y speed +1 for even i, −1 for odd i
- `x_direction`=0, collision-pending bits 0, counter 0
- state IDLE, `busy`=0, `frame_tick`=0

Divider:
- Free-running counter runs in every state.
- When counter == DIVIDER−1 it wraps to 0; that cycle is a "tick".

State machine:
- IDLE: on tick → SCAN with idx=0.
- SCAN: service ghost idx; idx++. After idx = NUM_GHOSTS−1 → DONE.
- DONE: one cycle, `frame_tick`=1, → IDLE.

Collision latch:
- `collision[i]` with `enable[i]`=1 sets pending[i].
- Servicing ghost i clears pending[i]. A set in the same cycle wins, so pending stays 1.
- Collisions are ignored while `enable[i]`=0.

Service of ghost i, with priority order:
1. `enable[i]`=0: no change to any of its state; pending[i] cleared.
2. pending[i]=1: negate both speeds, toggle `x_direction[i]`. Position is unchanged this sweep.
3. Otherwise, per axis, nx = x + sx in 12-bit signed arithmetic:
   - If nx ≤ BORDER or nx ≥ SCREEN_W−BORDER−OBJ_SIZE: negate sx, toggle `x_direction[i]`, x unchanged.
   - Else x ← nx.
   - Y uses the same rule with SCREEN_H and no direction flag. The two axes are independent.

## Timing
- All outputs are registered.
- Tick in cycle T: SCAN occupies T+1..T+NUM_GHOSTS. Ghost i's outputs change at the edge ending cycle T+1+i.
- DONE is cycle T+1+NUM_GHOSTS: `frame_tick`=1 there, `busy`=1 from T+1 through T+1+NUM_GHOSTS.
- Tick period is exactly DIVIDER clocks. The parameter rule guarantees a tick never lands outside IDLE.
- Ghosts not yet serviced keep their old values, so the bus is mid-update while `busy`=1. Consumers sample on `frame_tick`.
- `resetN` asserted mid-sweep aborts immediately to reset values. The sweep does not resume.

## Test plan
Use DIVIDER=8 and NUM_GHOSTS=4.
- Reset: x = 6/134/262/390, all y = 240, `x_direction`=0, `busy`=0 → hold 3 cycles after release with no output change.
- First tick: ghost0 → (7,241), ghost1 → (135,239), one ghost updating per cycle; `frame_tick` one cycle after ghost3 updates; 8-cycle tick period.
- Walls:
  - Ghost3 x reaches 570; next sweep x stays 570, `x_direction[3]`=1, then 569.
  - Ghost1 y reaches 6; next sweep y stays 6, then 7.
- Collision: 1-cycle pulse on `collision[2]` mid-interval → next sweep ghost2 position unchanged, `x_direction[2]`=1; following sweep x−1 and y−1.
- Collision coincident with ghost2's service cycle → not consumed; reversal applies on the following sweep.
- Enable and reset: `enable[1]`=0 → ghost1 frozen across 5 sweeps and collisions on it ignored. Assert `resetN` during SCAN → all outputs return to reset values asynchronously.
